// File: rtl/fifo_write.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write
// Brief    : Latches a packed word and byte count on an fs start request, then
//            writes the bytes MSB-first into a byte-wide FIFO with full
//            backpressure, signalling completion on fd.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write #(
    parameter int MAX_BYTES = 12,
    parameter int CNT_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic [CNT_W-1:0]       byte_num,
    input  logic                   fs,
    output logic                   fd,
    output logic [7:0]             fifo_txd,
    output logic                   fifo_txen,
    input  logic                   fifo_full,
    output logic [1:0]             so
);

    localparam int             c_data_w = 8 * MAX_BYTES;
    localparam logic [CNT_W-1:0] c_max_n  = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_work = 2'd2;
    localparam logic [1:0] c_last = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_data_w-1:0] r_shift;
    logic [CNT_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    w_idx_nxt;
    logic [CNT_W-1:0]    w_n_clamped;
    logic                w_wr;

    assign w_n_clamped = (byte_num > c_max_n) ? c_max_n : byte_num;
    assign w_wr        = (r_state == c_work) && !fifo_full;
    assign w_idx_nxt   = r_idx + c_one;

    // Combinational from the state register so an async reset drops them at once.
    assign fifo_txen = w_wr;
    assign fd        = (r_state == c_last);
    assign so        = r_state;
    // Top byte of the shift register is itself registered and holds through stalls.
    assign fifo_txd  = r_shift[c_data_w-1 -: 8];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (fs) begin
                    w_state_nxt = c_load;
                end
            end
            c_load: begin
                w_state_nxt = (w_n_clamped == '0) ? c_last : c_work;
            end
            c_work: begin
                if (w_wr && (w_idx_nxt == r_n)) begin
                    w_state_nxt = c_last;
                end
            end
            c_last: begin
                if (!fs) begin
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_shift <= '0;
            r_idx   <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_load) begin
                r_shift <= data;
                r_idx   <= '0;
                r_n     <= w_n_clamped;
            end else if (w_wr) begin
                r_shift <= {r_shift[c_data_w-9:0], 8'h00};
                r_idx   <= w_idx_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write
// Brief    : Directed self-checking bench for fifo_write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write;

    logic        clk;
    logic        rst;
    logic [95:0] data;
    logic [3:0]  byte_num;
    logic        fs;
    logic        fd;
    logic [7:0]  fifo_txd;
    logic        fifo_txen;
    logic        fifo_full;
    logic [1:0]  so;

    fifo_write #(.MAX_BYTES(12), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .byte_num  (byte_num),
        .fs        (fs),
        .fd        (fd),
        .fifo_txd  (fifo_txd),
        .fifo_txen (fifo_txen),
        .fifo_full (fifo_full),
        .so        (so)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [95:0] c_d1 = 96'h0102030405060708090A0B0C;
    localparam logic [95:0] c_d2 = 96'hA0A1A2A3A4A5A6A7A8A9AAAB;
    localparam logic [95:0] c_d3 = 96'h5152535455565758595A5B5C;

    int n_cmp;
    int n_err;

    int cyc, nwr, first_txen, last_txen, first_fd, fd_cnt;
    int fs_len, full_lo, full_hi;
    logic [7:0] wr_log [0:31];
    logic [7:0] txd_hist [0:63];
    logic       txen_hist [0:63];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [95:0] d, input int k);
        return d[95-8*k -: 8];
    endfunction

    task automatic start_txn(input int fsl, input int flo, input int fhi);
        cyc        = 0;
        nwr        = 0;
        first_txen = -1;
        last_txen  = -1;
        first_fd   = -1;
        fd_cnt     = 0;
        fs_len     = fsl;
        full_lo    = flo;
        full_hi    = fhi;
    endtask

    // Inputs are applied #1 after a posedge; outputs are observed at the negedge.
    task automatic step();
        fs        = (cyc < fs_len);
        fifo_full = (cyc >= full_lo) && (cyc <= full_hi);
        @(negedge clk);
        if (cyc < 64) begin
            txen_hist[cyc] = fifo_txen;
            txd_hist[cyc]  = fifo_txd;
        end
        if (fifo_txen) begin
            if (nwr < 32) wr_log[nwr] = fifo_txd;
            nwr++;
            if (first_txen < 0) first_txen = cyc;
            last_txen = cyc;
        end
        if (fd) begin
            fd_cnt++;
            if (first_fd < 0) first_fd = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_bytes(input string tag, input logic [95:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_byte%0d", tag, k), {24'h0, wr_log[k]}, {24'h0, byte_of(d, k)});
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        data      = '0;
        byte_num  = '0;
        fs        = 1'b0;
        fifo_full = 1'b0;
        start_txn(0, 100, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_so",   {30'h0, so}, 32'd0);
        check("rst_fd",   {31'h0, fd}, 32'd0);
        check("rst_txen", {31'h0, fifo_txen}, 32'd0);
        check("rst_txd",  {24'h0, fifo_txd}, 32'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal send with fs held through LAST
        data = c_d1; byte_num = 4'd12;
        start_txn(100, 100, 0);
        run(16);
        check("norm_first_txen", first_txen, 2);
        check("norm_last_txen", last_txen, 13);
        check("norm_nwr", nwr, 12);
        check("norm_first_fd", first_fd, 14);
        check("norm_fd_held", fd_cnt, 2);
        check("norm_so_last", {30'h0, so}, 32'd3);
        check_bytes("norm", c_d1, 12);
        fs_len = 0;
        step();
        check("norm_idle_fd", {31'h0, fd}, 32'd0);
        check("norm_idle_so", {30'h0, so}, 32'd0);

        // Backpressure while byte 04 is presented
        start_txn(100, 5, 7);
        run(19);
        check("bp_nwr", nwr, 12);
        check("bp_stall_txen", {31'h0, txen_hist[6]}, 32'd0);
        check("bp_stall_txd", {24'h0, txd_hist[7]}, 32'h04);
        check("bp_resume_txd", {24'h0, txd_hist[8]}, 32'h04);
        check("bp_first_fd", first_fd, 17);
        check_bytes("bp", c_d1, 12);
        fs_len = 0; run(2);

        // Full on the last byte defers both the write and fd
        start_txn(100, 13, 13);
        run(17);
        check("lastfull_nwr", nwr, 12);
        check("lastfull_txd", {24'h0, txd_hist[14]}, 32'h0C);
        check("lastfull_first_fd", first_fd, 15);
        fs_len = 0; run(2);

        // byte_num = 0
        byte_num = 4'd0;
        start_txn(100, 100, 0);
        run(6);
        check("n0_nwr", nwr, 0);
        check("n0_first_fd", first_fd, 2);
        fs_len = 0; run(2);

        // byte_num = 1
        byte_num = 4'd1;
        start_txn(100, 100, 0);
        run(6);
        check("n1_nwr", nwr, 1);
        check("n1_byte", {24'h0, wr_log[0]}, 32'h01);
        check("n1_first_fd", first_fd, 3);
        fs_len = 0; run(2);

        // byte_num = 15 clamps to 12
        byte_num = 4'd15;
        start_txn(100, 100, 0);
        run(18);
        check("n15_nwr", nwr, 12);
        check("n15_first_fd", first_fd, 14);
        fs_len = 0; run(2);

        // Single-cycle fs pulse
        byte_num = 4'd12;
        start_txn(1, 100, 0);
        run(18);
        check("pulse_nwr", nwr, 12);
        check("pulse_fd_cnt", fd_cnt, 1);
        check("pulse_so", {30'h0, so}, 32'd0);

        // Reset after 5 writes
        start_txn(100, 100, 0);
        run(7);
        check("rstmid_nwr", nwr, 5);
        rst = 1'b1;
        #1;
        check("rstmid_txen", {31'h0, fifo_txen}, 32'd0);
        check("rstmid_fd", {31'h0, fd}, 32'd0);
        check("rstmid_so", {30'h0, so}, 32'd0);
        fs = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        data = c_d2;
        start_txn(100, 100, 0);
        run(16);
        check("rstnew_nwr", nwr, 12);
        check("rstnew_first_fd", first_fd, 14);
        check_bytes("rstnew", c_d2, 12);

        // fs kept high through LAST: no retrigger
        start_txn(100, 100, 0);
        run(6);
        check("b2b_hold_nwr", nwr, 0);
        check("b2b_hold_so", {30'h0, so}, 32'd3);
        fs_len = 0; step();
        check("b2b_gap_so", {30'h0, so}, 32'd0);

        // Fresh data latched in LOAD; later changes on data are ignored
        data = c_d3;
        start_txn(100, 100, 0);
        run(3);
        data = 96'hFFEEDDCCBBAA998877665544;
        byte_num = 4'd2;
        run(13);
        check("b2b_nwr", nwr, 12);
        check_bytes("b2b", c_d3, 12);
        fs_len = 0; run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
